// File: rtl/garage_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : garage_cmd_sequencer
// Description : Garage door command sequencer. Turns wall, remote and
//               auto-close requests into one-cycle Activate pulses, supervises
//               the motor response, motion timeout and obstruction, and
//               latches a FAULT state that kills motor power until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module garage_cmd_sequencer #(
  parameter int SETTLE_CYC     = 16,
  parameter int AUTO_CLOSE_CYC = 1000,
  parameter int TIMEOUT_CYC    = 4096,
  parameter int CNT_W          = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Wall_Btn,
  input  logic       Remote_Btn,
  input  logic       Obstruct,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       UP_M,
  input  logic       DN_M,
  input  logic       Clr_Fault,
  output logic       Activate,
  output logic       Mtr_Kill,
  output logic       Fault,
  output logic       Busy,
  output logic [1:0] Last_Src
);

  localparam logic [2:0] c_st_idle      = 3'd0;
  localparam logic [2:0] c_st_issue     = 3'd1;
  localparam logic [2:0] c_st_wait_move = 3'd2;
  localparam logic [2:0] c_st_moving    = 3'd3;
  localparam logic [2:0] c_st_settle    = 3'd4;
  localparam logic [2:0] c_st_fault     = 3'd5;

  localparam logic [1:0] c_src_wall   = 2'b01;
  localparam logic [1:0] c_src_remote = 2'b10;
  localparam logic [1:0] c_src_auto   = 2'b11;

  localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_wait_last    = CNT_W'(3);
  localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] c_auto_last    = CNT_W'(AUTO_CLOSE_CYC - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ac_cnt;
  logic             r_wall_q;
  logic             r_remote_q;
  logic [1:0]       r_last_src;

  logic       w_wall_rise;
  logic       w_remote_rise;
  logic       w_any_rise;
  logic       w_limits_bad;
  logic       w_ac_run;
  logic       w_auto_req;
  logic       w_accept;
  logic [1:0] w_src;

  assign w_wall_rise   = Wall_Btn & ~r_wall_q;
  assign w_remote_rise = Remote_Btn & ~r_remote_q;
  assign w_any_rise    = w_wall_rise | w_remote_rise;
  assign w_limits_bad  = UP_Max & DN_Max;

  // Auto-close only runs while idle with the door fully open and the beam clear
  assign w_ac_run   = (r_state == c_st_idle) & UP_Max & ~DN_Max & ~Obstruct & ~w_any_rise;
  assign w_auto_req = w_ac_run & (r_ac_cnt == c_auto_last);

  // A request needs a definite door position and must not close onto an obstruction
  assign w_accept = (r_state == c_st_idle) & (w_any_rise | w_auto_req) &
                    (UP_Max ^ DN_Max) & ~(UP_Max & Obstruct);

  // Priority wall > remote > auto-close; losing requests are simply dropped
  assign w_src = w_wall_rise   ? c_src_wall   :
                 w_remote_rise ? c_src_remote : c_src_auto;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= c_st_idle;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a double limit switch reading overrides everything
  always_comb begin
    w_next_state = r_state;
    if (w_limits_bad) begin
      w_next_state = c_st_fault;
    end else begin
      case (r_state)
        c_st_idle:      if (w_accept) w_next_state = c_st_issue;
        c_st_issue:     w_next_state = c_st_wait_move;
        c_st_wait_move: begin
          if (UP_M | DN_M)                w_next_state = c_st_moving;
          else if (r_cnt >= c_wait_last)  w_next_state = c_st_fault;
        end
        c_st_moving: begin
          if (DN_M & Obstruct)               w_next_state = c_st_fault;
          else if (!UP_M && !DN_M)           w_next_state = c_st_settle;
          else if (r_cnt >= c_timeout_last)  w_next_state = c_st_fault;
        end
        c_st_settle:    if (r_cnt >= c_settle_last) w_next_state = c_st_idle;
        c_st_fault:     if (Clr_Fault) w_next_state = c_st_settle;
        default:        w_next_state = c_st_idle;
      endcase
    end
  end

  // Shared per-state cycle counter: restarts on every state change, saturates
  always_ff @(posedge CLK) begin
    if (RST)                          r_cnt <= '0;
    else if (w_next_state != r_state) r_cnt <= '0;
    else if (r_cnt != c_cnt_max)      r_cnt <= r_cnt + c_one;
  end

  // Auto-close idle counter: clears whenever the open-idle condition breaks
  always_ff @(posedge CLK) begin
    if (RST)                          r_ac_cnt <= '0;
    else if (!w_ac_run || w_auto_req) r_ac_cnt <= '0;
    else if (r_ac_cnt != c_cnt_max)   r_ac_cnt <= r_ac_cnt + c_one;
  end

  // Button edge registers and source of the last issued command
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wall_q   <= 1'b0;
      r_remote_q <= 1'b0;
      r_last_src <= 2'b00;
    end else begin
      r_wall_q   <= Wall_Btn;
      r_remote_q <= Remote_Btn;
      if (w_accept) r_last_src <= w_src;
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    Activate = (r_state == c_st_issue);
    Mtr_Kill = (r_state == c_st_fault);
    Fault    = (r_state == c_st_fault);
    Busy     = (r_state != c_st_idle);
    Last_Src = r_last_src;
  end

endmodule
`default_nettype wire

// File: doc/garage_cmd_sequencer.md
GARAGE_CMD_SEQUENCER -- requirements
Module: garage_cmd_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16: idle cycles enforced after motion ends.
REQ-002 SHALL have parameter AUTO_CLOSE_CYC, default 1000: open-idle cycles before an auto-close request.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 4096: maximum cycles of continuous motion.
REQ-004 SHALL have parameter CNT_W, default 16: width of the shared cycle counter, sized to hold the largest parameter.
REQ-005 SHALL have port CLK, input, 1: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port RST, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port Wall_Btn, input, 1: wall button level, pre-synchronised.
REQ-008 SHALL have port Remote_Btn, input, 1: remote receiver level, pre-synchronised.
REQ-009 SHALL have port Obstruct, input, 1: beam broken while high.
REQ-010 SHALL have ports UP_Max and DN_Max, input, 1 each: the door-open and door-closed limit switches.
REQ-011 SHALL have ports UP_M and DN_M, input, 1 each: motor drive outputs monitored from the door motor controller.
REQ-012 SHALL have port Activate, output, 1: one-cycle command pulse to the motor controller.
REQ-013 SHALL have port Mtr_Kill, output, 1: gates motor power off externally.
REQ-014 SHALL have port Fault, output, 1: the sequencer is in FAULT.
REQ-015 SHALL have port Busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port Last_Src, output, 2: source of the last issued command: 01 wall, 10 remote, 11 auto-close.
REQ-017 SHALL have port Clr_Fault, input, 1: fault-clear request.

Function
REQ-018 SHALL edge-detect Wall_Btn and Remote_Btn with registered previous values; only 0->1 transitions form requests.
REQ-019 SHALL use the states IDLE, ISSUE, WAIT_MOVE, MOVING, SETTLE and FAULT, all registered.
REQ-020 In IDLE, SHALL accept a request only when exactly one of UP_Max and DN_Max is high.
REQ-021 In IDLE, SHALL reject a request while UP_Max=1 and Obstruct=1, because that request would close the door.
REQ-022 SHALL apply the priority wall > remote > auto-close to simultaneous requests; exactly one command is issued and the losers are dropped.
REQ-023 SHALL drop requests arriving outside IDLE, with no queuing.
REQ-024 On an accepted request, SHALL go IDLE->ISSUE, update Last_Src, and drive Activate=1 for exactly the ISSUE cycle.
REQ-025 After ISSUE, SHALL go to WAIT_MOVE.
REQ-026 In WAIT_MOVE, SHALL go to MOVING when UP_M or DN_M is seen within 4 cycles, otherwise to FAULT.
REQ-027 In MOVING, SHALL count cycles and go to FAULT when the count reaches TIMEOUT_CYC-1.
REQ-028 In MOVING, SHALL go to FAULT on the cycle after DN_M=1 and Obstruct=1 are seen together.
REQ-029 In MOVING, SHALL go to SETTLE on UP_M=0 and DN_M=0.
REQ-030 In SETTLE, SHALL hold SETTLE_CYC cycles and then go to IDLE; requests in SETTLE are dropped.
REQ-031 In IDLE with UP_Max=1, DN_Max=0 and Obstruct=0, SHALL increment the auto-close counter each cycle.
REQ-032 SHALL raise an auto-close request when the auto-close counter equals AUTO_CLOSE_CYC-1, then clear the counter.
REQ-033 SHALL clear the auto-close counter on Obstruct=1, on any button edge, on leaving IDLE, and when UP_Max=0.
REQ-034 SHALL go to FAULT from any state on UP_Max=1 together with DN_Max=1; this takes priority over every other transition.
REQ-035 In FAULT, SHALL drive Mtr_Kill=1 and Fault=1 and issue no Activate.
REQ-036 SHALL leave FAULT for SETTLE only on Clr_Fault=1 while UP_Max and DN_Max are not both high.
REQ-037 SHALL saturate all counters at their terminal value and never wrap.
REQ-038 SHALL have combinational outputs that depend only on state and registers, never directly on inputs.

Reset
REQ-039 On RST=1 at a clock edge, SHALL set the state to IDLE and all counters and edge registers to 0.
REQ-040 During and after reset, SHALL set Activate=0, Mtr_Kill=0, Fault=0, Busy=0 and Last_Src=00.
REQ-041 SHALL abort any state on reset mid-operation, including FAULT, with no Activate emitted on the following cycle.

Verification
REQ-042 Closed door (DN_Max=1), Wall_Btn 0->1: Activate=1 one cycle later, Last_Src=01, then DN_M/UP_M response -> MOVING; motion ends -> Busy=1 for 16 more cycles, then 0.
REQ-043 Wall_Btn and Remote_Btn rise in the same cycle: exactly one Activate pulse, Last_Src=01.
REQ-044 Door open (UP_Max=1), idle for 1000 cycles: Activate pulse on cycle 1000, Last_Src=11; Obstruct pulsed at cycle 500 restarts the count, so the pulse lands at cycle 1500.
REQ-045 MOVING with DN_M=1, Obstruct asserted: Fault=1 and Mtr_Kill=1 next cycle; Clr_Fault -> SETTLE -> IDLE, with Fault=0.
REQ-046 Activate issued, motor never responds: FAULT after the 4-cycle window; separately, DN_M held for 4096 cycles -> FAULT.
REQ-047 UP_Max=DN_Max=1 injected while IDLE -> FAULT; RST=1 mid-MOVING -> all outputs 0 next cycle.
